// File: rtl/efpga_mac_acc_if.sv
// Purpose : handshake/data bundle between the MAE multiplier, the MAC accumulator and its consumer.
// Latency : none, wires only.
// Backpressure : carries P_READY upstream and ACC_READY from downstream.
// Signals : CLR abort; P/P_VALID/P_LAST/P_READY product side; ACC/ACC_VALID/ACC_READY/OVF/CNT result side.
interface efpga_mac_acc_if #(
   parameter int P_WIDTH   = 40,
   parameter int ACC_WIDTH = 48
);
   logic                        CLR;
   logic signed [P_WIDTH-1:0]   P;
   logic                        P_VALID;
   logic                        P_LAST;
   logic                        P_READY;
   logic signed [ACC_WIDTH-1:0] ACC;
   logic                        ACC_VALID;
   logic                        ACC_READY;
   logic                        OVF;
   logic [7:0]                  CNT;

   // Environment view: drives products, abort and result acceptance.
   modport master (
      output CLR, P, P_VALID, P_LAST, ACC_READY,
      input  P_READY, ACC, ACC_VALID, OVF, CNT
   );

   // Accumulator view.
   modport slave (
      input  CLR, P, P_VALID, P_LAST, ACC_READY,
      output P_READY, ACC, ACC_VALID, OVF, CNT
   );
endinterface

// File: rtl/efpga_mac_acc.sv
// Purpose : accumulates signed multiplier products into a dot-product result (wrap or saturate).
// Latency : ACC_VALID rises the cycle after the P_LAST term is accepted.
// Backpressure : P_READY low while a result is held; result held until ACC_READY.
// Ports : CLK, SRST (sync, active high) plain; everything else through efpga_mac_acc_if.slave.
module efpga_mac_acc #(
   parameter int P_WIDTH   = 40,
   parameter int ACC_WIDTH = 48,
   parameter int SATURATE  = 0
) (
   input  logic           CLK,
   input  logic           SRST,
   efpga_mac_acc_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_HOLD  = 2'd2
   } state_t;

   localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

   state_t                      r_state, w_state_nxt;
   logic signed [ACC_WIDTH-1:0] r_acc, w_acc_nxt;
   logic [7:0]                  r_cnt, w_cnt_nxt;
   logic                        r_ovf, w_ovf_nxt;

   logic                        w_accept;
   logic signed [ACC_WIDTH-1:0] w_p_ext;
   logic signed [ACC_WIDTH-1:0] w_sum;
   logic signed [ACC_WIDTH-1:0] w_add_res;
   logic                        w_add_ovf;

   // Ready is a pure function of state so upstream never sees a combinational path.
   assign bus.P_READY   = (r_state != S_HOLD);
   assign bus.ACC_VALID = (r_state == S_HOLD);
   assign bus.ACC       = r_acc;
   assign bus.CNT       = r_cnt;
   assign bus.OVF       = r_ovf;

   assign w_accept = bus.P_VALID && bus.P_READY;
   assign w_p_ext  = ACC_WIDTH'(bus.P);     // signed cast sign-extends
   assign w_sum    = r_acc + w_p_ext;

   // Signed overflow: operands agree in sign but the sum does not.
   assign w_add_ovf = (r_acc[ACC_WIDTH-1] == w_p_ext[ACC_WIDTH-1]) &&
                      (w_sum[ACC_WIDTH-1] != r_acc[ACC_WIDTH-1]);

   // On saturation the clamp direction follows the accumulator sign before the add.
   always_comb begin
      w_add_res = w_sum;
      if ((SATURATE != 0) && w_add_ovf) begin
         w_add_res = r_acc[ACC_WIDTH-1] ? ACC_MIN : ACC_MAX;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_acc_nxt   = r_acc;
      w_cnt_nxt   = r_cnt;
      w_ovf_nxt   = r_ovf;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_acc_nxt   = w_p_ext;
               w_cnt_nxt   = 8'd1;
               w_ovf_nxt   = 1'b0;
               w_state_nxt = bus.P_LAST ? S_HOLD : S_ACCUM;
            end
         end
         S_ACCUM: begin
            if (w_accept) begin
               w_acc_nxt   = w_add_res;
               w_cnt_nxt   = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;
               w_ovf_nxt   = r_ovf | w_add_ovf;
               w_state_nxt = bus.P_LAST ? S_HOLD : S_ACCUM;
            end
         end
         S_HOLD: begin
            if (bus.ACC_READY) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
      // Abort wins over any accept or result hand-off in the same cycle.
      if (bus.CLR) begin
         w_state_nxt = S_IDLE;
         w_acc_nxt   = '0;
         w_cnt_nxt   = 8'd0;
         w_ovf_nxt   = 1'b0;
      end
   end

   always_ff @(posedge CLK) begin
      if (SRST) begin
         r_state <= S_IDLE;
         r_acc   <= '0;
         r_cnt   <= 8'd0;
         r_ovf   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_acc   <= w_acc_nxt;
         r_cnt   <= w_cnt_nxt;
         r_ovf   <= w_ovf_nxt;
      end
   end

endmodule

// File: doc/efpga_mac_acc.md
EFPGA_MAC_ACC -- requirements
Module: efpga_mac_acc

Interface
REQ-001 The block SHALL sit directly downstream of the MAE multiplier and consume its signed product P.
REQ-002 Parameters SHALL be:
- P_WIDTH, default 40: product width.
- ACC_WIDTH, default 48: accumulator width; ACC_WIDTH >= P_WIDTH.
- SATURATE, default 0: 1 = clamp on overflow; 0 = two's-complement wrap.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 Ports SHALL be:
- CLK  in  1  clock; all state changes on its rising edge.
- SRST  in  1  synchronous active-high reset.
- CLR  in  1  synchronous abort of the current accumulation.
- P  in  P_WIDTH  signed product from the multiplier.
- P_VALID  in  1  P carries a product this cycle.
- P_LAST  in  1  P is the final term of a dot product.
- P_READY  out  1  block can accept a product.
- ACC  out  ACC_WIDTH  signed accumulated result.
- ACC_VALID  out  1  ACC holds a completed result.
- ACC_READY  in  1  downstream accepts the result.
- OVF  out  1  overflow occurred in this accumulation.
- CNT  out  8  number of terms accumulated.

Function
REQ-005 A product SHALL be accepted on a rising edge where P_VALID=1 and P_READY=1; P_LAST is sampled only on accept.
REQ-006 The FSM SHALL have states IDLE, ACCUM and HOLD; P_READY=1 in IDLE and ACCUM, 0 in HOLD; P_READY SHALL depend on state only.
REQ-007 IDLE, on accept:
- ACC <= sign-extended P; CNT <= 1; OVF <= 0.
- Next state HOLD if P_LAST=1, else ACCUM.
REQ-008 ACCUM, on accept:
- ACC <= ACC + sign-extended P; CNT <= CNT+1, saturating at 255.
- Next state HOLD if P_LAST=1, else stay in ACCUM.
REQ-009 ACCUM with no accept SHALL hold all state.
REQ-010 HOLD behaviour:
- ACC_VALID=1 and ACC, OVF, CNT held stable.
- On ACC_READY=1, go to IDLE at that edge; ACC_VALID=0 from the next cycle.
REQ-011 Latency: with P_LAST accepted at edge N, ACC_VALID SHALL be 1 in the cycle after edge N.
REQ-012 Throughput: one product per cycle in IDLE/ACCUM; at least one bubble between results, since P_READY=0 while in HOLD.
REQ-013 Overflow is signed overflow of the ACC_WIDTH-bit addition; on overflow OVF SHALL be set and remain set (sticky) until the next IDLE accept.
REQ-014 On overflow with SATURATE=1, ACC SHALL clamp to 2^(ACC_WIDTH-1)-1 (positive) or -2^(ACC_WIDTH-1) (negative); later terms still add to the clamped value, with the same saturation.
REQ-015 On overflow with SATURATE=0, ACC SHALL wrap modulo 2^ACC_WIDTH.
REQ-016 ACC_VALID SHALL be 0 outside HOLD; ACC, CNT and OVF keep their last values in IDLE.
REQ-017 CLR=1 SHALL force IDLE with ACC=0, CNT=0, OVF=0 from any state, including HOLD, dropping ACC_VALID.
REQ-018 Priority: CLR overrides any accept or ACC_READY in the same cycle; a product presented with CLR=1 is discarded.
REQ-019 P_VALID=1 while P_READY=0 SHALL be ignored; upstream holds P until accepted.
REQ-020 Handshake outputs SHALL be free of X after reset, whatever the input values.

Reset
REQ-021 SRST=1 at a rising edge SHALL force IDLE, ACC=0, CNT=0, OVF=0, ACC_VALID=0, P_READY=1 from the next cycle.
REQ-022 SRST SHALL take priority over CLR and all handshakes.
REQ-023 SRST asserted mid-accumulation or in HOLD SHALL discard the partial or pending result.
REQ-024 Without SRST, output state after power-up is undefined; benches SHALL assert SRST for at least one cycle first.

Verification
REQ-025 Basic dot product: products 3, -5, 10 on consecutive cycles, last on third, ACC_READY=1 -> ACC=8, CNT=3, OVF=0, ACC_VALID high exactly one cycle, one cycle after the third accept.
REQ-026 Backpressure: single product 7 with P_LAST, ACC_READY=0 for 4 cycles -> ACC_VALID and ACC=7 held, P_READY=0 for all 4 cycles; release -> IDLE next cycle.
REQ-027 Saturation, ACC_WIDTH=41, SATURATE=1: terms 2^39-1, 2^39-1, 5 (last) -> ACC=2^40-1, OVF=1; with SATURATE=0 the same stimulus -> wrapped sum -2^40+3, OVF=1.
REQ-028 CLR collision: CLR=1 in the same cycle as accept of P=9 while in ACCUM with ACC=4 -> next cycle IDLE, ACC=0, CNT=0, product 9 discarded.
REQ-029 Reset mid-operation: SRST pulse after 2 of 3 terms -> outputs reset; a new 1-term accumulation of -1 -> ACC=-1 (all ones), CNT=1.
REQ-030 CNT saturation: 300 accepted terms of 1, last on the 300th -> ACC=300, CNT=255.
